sb_rx_transaction_decoder: RTL and testbench

//  Receive end of the USB4 sideband link: deserializes the sbrx line and decodes framed sideband transactions.

---
 rtl/sb_rx_transaction_decoder.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_sb_rx_transaction_decoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_rx_transaction_decoder.sv
// sb_rx_transaction_decoder
//   Receive side of the USB4 sideband link. Synchronizes and deserializes the
//   sbrx line (start bit, 8 data bits LSB first, stop bit) and decodes the
//   framed sideband transactions carried on it:
//     LT : DLE, LSE, ~LSE
//     AT : DLE, STX, payload (DLE stuffed), CRC hi, CRC lo, DLE, ETX
//   Each good transaction is reported with a one-cycle valid pulse; the
//   decoded data is held until the next transaction of the same kind.
// Ports
//   sb_clk, rst         clock, synchronous active-high reset
//   enable              0 holds both FSMs idle and ignores the line
//   sbrx                asynchronous serial input, idle high
//   lt_valid, lt_lse    LT decoded pulse / LSE byte of the last good LT
//   at_valid            AT decoded pulse
//   at_is_cmd           1: command STX (05), 0: response STX (04)
//   at_len, at_data     payload byte count / payload, byte0 in [7:0]
//   frame_err, crc_err  error pulses
//   busy                a character or transaction is in progress
// Build option
//   SB_RX_CRC_CHECK_EN  when defined, the CRC-16 (poly 8005, init FFFF, over
//                       STX and unstuffed payload) is checked and a mismatch
//                       pulses crc_err instead of at_valid. When undefined no
//                       CRC logic exists and crc_err is tied low.
module sb_rx_transaction_decoder #(
   parameter int CLKS_PER_BIT      = 10,
   parameter int MAX_PAYLOAD_BYTES = 8
) (
   input  logic                                   sb_clk,
   input  logic                                   rst,
   input  logic                                   enable,
   input  logic                                   sbrx,
   output logic                                   lt_valid,
   output logic [7:0]                             lt_lse,
   output logic                                   at_valid,
   output logic                                   at_is_cmd,
   output logic [$clog2(MAX_PAYLOAD_BYTES+1)-1:0] at_len,
   output logic [8*MAX_PAYLOAD_BYTES-1:0]         at_data,
   output logic                                   frame_err,
   output logic                                   crc_err,
   output logic                                   busy
);

   localparam int LW     = $clog2(MAX_PAYLOAD_BYTES + 1);
   localparam int NSTORE = MAX_PAYLOAD_BYTES + 2;     // payload plus CRC bytes
   localparam int CW     = $clog2(NSTORE + 1);
   localparam int KW     = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_FULL = CW'(NSTORE);
   localparam logic [7:0] DLE = 8'hFE, ETX = 8'h40, STX_CMD = 8'h05, STX_RSP = 8'h04;

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_st_t;
   typedef enum logic [2:0] {P_IDLE, P_DLE, P_LT, P_AT, P_AT_DLE} par_st_t;

   logic [2:0]              sync_q, sync_d;      // [1] = synchronized line, [2] = previous
   bit_st_t                 bst_q, bst_d;
   logic [KW-1:0]           clk_cnt_q, clk_cnt_d;
   logic [2:0]              bit_idx_q, bit_idx_d;
   logic [7:0]              shift_q, shift_d;
   logic                    brk_q, brk_d;        // stop bit was low, waiting for line high
   par_st_t                 pst_q, pst_d;
   logic [7:0]              lse_q, lse_d;
   logic                    cmd_q, cmd_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [8*NSTORE-1:0]     buf_q, buf_d;
   logic                    lt_valid_q, lt_valid_d, at_valid_q, at_valid_d;
   logic [7:0]              lt_lse_q, lt_lse_d;
   logic                    at_is_cmd_q, at_is_cmd_d;
   logic [LW-1:0]           at_len_q, at_len_d;
   logic [8*MAX_PAYLOAD_BYTES-1:0] at_data_q, at_data_d;
   logic                    frame_err_q, frame_err_d, crc_err_q, crc_err_d;
   logic                    rx, fall, byte_stb, stop_err, store_en;
   logic [7:0]              store_byte;

`ifdef SB_RX_CRC_CHECK_EN
   logic [15:0] crc_q, crc_d, rx_crc;
   logic [7:0]  fold_byte;

   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction
`endif

   assign rx   = sync_q[1];
   assign fall = sync_q[2] & ~sync_q[1];

   always_comb begin
      sync_d      = {sync_q[1:0], sbrx};
      bst_d       = bst_q;
      clk_cnt_d   = clk_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      brk_d       = brk_q;
      pst_d       = pst_q;
      lse_d       = lse_q;
      cmd_d       = cmd_q;
      cnt_d       = cnt_q;
      buf_d       = buf_q;
      lt_valid_d  = 1'b0;
      lt_lse_d    = lt_lse_q;
      at_valid_d  = 1'b0;
      at_is_cmd_d = at_is_cmd_q;
      at_len_d    = at_len_q;
      at_data_d   = at_data_q;
      frame_err_d = 1'b0;
      crc_err_d   = 1'b0;
      byte_stb    = 1'b0;
      stop_err    = 1'b0;
      store_en    = 1'b0;
      store_byte  = '0;
`ifdef SB_RX_CRC_CHECK_EN
      crc_d     = crc_q;
      // The CRC runs two bytes behind the store pointer, since the last two
      // stored bytes turn out to be the CRC itself once ETX arrives.
      fold_byte = '0;
      rx_crc    = '0;
      for (int i = 0; i < NSTORE - 1; i++) begin
         if (cnt_q == CW'(i + 2)) begin
            fold_byte = buf_q[8*i +: 8];
            rx_crc    = {buf_q[8*i +: 8], buf_q[8*(i+1) +: 8]};
         end
      end
`endif

      if (!enable) begin
         bst_d = B_IDLE;
         pst_d = P_IDLE;
         brk_d = 1'b0;
      end else begin
         // ---- bit FSM ----
         case (bst_q)
            B_IDLE: if (fall) begin
               bst_d     = B_START;
               clk_cnt_d = KW'(CLKS_PER_BIT/2 - 1);
            end
            B_START: if (clk_cnt_q == '0) begin
               if (rx) bst_d = B_IDLE;           // false start / glitch
               else begin
                  bst_d     = B_DATA;
                  clk_cnt_d = KW'(CLKS_PER_BIT - 1);
                  bit_idx_d = '0;
               end
            end else clk_cnt_d = clk_cnt_q - 1'b1;
            B_DATA: if (clk_cnt_q == '0) begin
               shift_d   = {rx, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 1'b1;
               clk_cnt_d = KW'(CLKS_PER_BIT - 1);
               if (bit_idx_q == 3'd7) begin
                  bst_d = B_STOP;
                  brk_d = 1'b0;
               end
            end else clk_cnt_d = clk_cnt_q - 1'b1;
            default: if (clk_cnt_q == '0) begin   // B_STOP; counter parks at 0 on a break
               if (rx) begin
                  bst_d    = B_IDLE;
                  byte_stb = ~brk_q;
               end else if (!brk_q) begin
                  stop_err = 1'b1;
                  brk_d    = 1'b1;
               end
            end else clk_cnt_d = clk_cnt_q - 1'b1;
         endcase

         // ---- parser FSM ----
         if (stop_err) begin
            frame_err_d = 1'b1;
            pst_d       = P_IDLE;
         end else if (byte_stb) begin
            case (pst_q)
               P_IDLE: if (shift_q == DLE) pst_d = P_DLE;
               P_DLE: if (shift_q == STX_CMD || shift_q == STX_RSP) begin
                  pst_d = P_AT;
                  cmd_d = (shift_q == STX_CMD);
                  cnt_d = '0;
`ifdef SB_RX_CRC_CHECK_EN
                  crc_d = crc_upd(16'hFFFF, shift_q);
`endif
               end else begin
                  lse_d = shift_q;
                  pst_d = P_LT;
               end
               P_LT: begin
                  if (shift_q == ~lse_q) begin
                     lt_valid_d = 1'b1;
                     lt_lse_d   = lse_q;
                  end else frame_err_d = 1'b1;
                  pst_d = P_IDLE;
               end
               P_AT: if (shift_q == DLE) pst_d = P_AT_DLE;
                     else begin
                        store_en   = 1'b1;
                        store_byte = shift_q;
                     end
               default: begin                     // P_AT_DLE
                  pst_d = P_IDLE;
                  if (shift_q == DLE) begin
                     pst_d      = P_AT;
                     store_en   = 1'b1;
                     store_byte = DLE;
                  end else if (shift_q != ETX || cnt_q < CW'(2)) begin
                     frame_err_d = 1'b1;
`ifdef SB_RX_CRC_CHECK_EN
                  end else if (rx_crc != crc_q) begin
                     crc_err_d = 1'b1;
`endif
                  end else begin
                     at_valid_d  = 1'b1;
                     at_is_cmd_d = cmd_q;
                     at_len_d    = LW'(cnt_q - CW'(2));
                     for (int i = 0; i < MAX_PAYLOAD_BYTES; i++)
                        at_data_d[8*i +: 8] = (CW'(i) < cnt_q - CW'(2)) ? buf_q[8*i +: 8] : 8'h00;
                  end
               end
            endcase

            if (store_en) begin
               if (cnt_q == CNT_FULL) begin      // no room left: overflow
                  frame_err_d = 1'b1;
                  pst_d       = P_IDLE;
               end else begin
                  for (int i = 0; i < NSTORE; i++)
                     if (cnt_q == CW'(i)) buf_d[8*i +: 8] = store_byte;
                  cnt_d = cnt_q + 1'b1;
`ifdef SB_RX_CRC_CHECK_EN
                  if (cnt_q >= CW'(2)) crc_d = crc_upd(crc_q, fold_byte);
`endif
               end
            end
         end
      end
   end

   always_ff @(posedge sb_clk) begin
      if (rst) begin
         sync_q      <= 3'b111;
         bst_q       <= B_IDLE;
         clk_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         brk_q       <= 1'b0;
         pst_q       <= P_IDLE;
         lse_q       <= '0;
         cmd_q       <= 1'b0;
         cnt_q       <= '0;
         buf_q       <= '0;
         lt_valid_q  <= 1'b0;
         lt_lse_q    <= '0;
         at_valid_q  <= 1'b0;
         at_is_cmd_q <= 1'b0;
         at_len_q    <= '0;
         at_data_q   <= '0;
         frame_err_q <= 1'b0;
         crc_err_q   <= 1'b0;
`ifdef SB_RX_CRC_CHECK_EN
         crc_q       <= 16'hFFFF;
`endif
      end else begin
         sync_q      <= sync_d;
         bst_q       <= bst_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         brk_q       <= brk_d;
         pst_q       <= pst_d;
         lse_q       <= lse_d;
         cmd_q       <= cmd_d;
         cnt_q       <= cnt_d;
         buf_q       <= buf_d;
         lt_valid_q  <= lt_valid_d;
         lt_lse_q    <= lt_lse_d;
         at_valid_q  <= at_valid_d;
         at_is_cmd_q <= at_is_cmd_d;
         at_len_q    <= at_len_d;
         at_data_q   <= at_data_d;
         frame_err_q <= frame_err_d;
         crc_err_q   <= crc_err_d;
`ifdef SB_RX_CRC_CHECK_EN
         crc_q       <= crc_d;
`endif
      end
   end

   assign lt_valid  = lt_valid_q;
   assign lt_lse    = lt_lse_q;
   assign at_valid  = at_valid_q;
   assign at_is_cmd = at_is_cmd_q;
   assign at_len    = at_len_q;
   assign at_data   = at_data_q;
   assign frame_err = frame_err_q;
   assign crc_err   = crc_err_q;
   assign busy      = (bst_q != B_IDLE) || (pst_q != P_IDLE);

endmodule

// File: tb/tb_sb_rx_transaction_decoder.sv
// Directed bench for sb_rx_transaction_decoder (CLKS_PER_BIT=10, 8-byte payload).
module tb_sb_rx_transaction_decoder;
   localparam int CPB  = 10;
   localparam int MAXP = 8;

   logic          sb_clk = 1'b0;
   logic          rst = 1'b1, enable = 1'b0, sbrx = 1'b1;
   logic          lt_valid, at_valid, at_is_cmd, frame_err, crc_err, busy;
   logic [7:0]    lt_lse;
   logic [3:0]    at_len;
   logic [63:0]   at_data;

   int  n_cmp = 0, n_err = 0;
   int  n_lt = 0, n_at = 0, n_fe = 0, n_ce = 0;
   time at_t = 0, last_start_t = 0;

   sb_rx_transaction_decoder #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD_BYTES(MAXP)) dut (
      .sb_clk(sb_clk), .rst(rst), .enable(enable), .sbrx(sbrx),
      .lt_valid(lt_valid), .lt_lse(lt_lse), .at_valid(at_valid), .at_is_cmd(at_is_cmd),
      .at_len(at_len), .at_data(at_data), .frame_err(frame_err), .crc_err(crc_err),
      .busy(busy));

   always #5 sb_clk = ~sb_clk;

   // Pulse counters, sampled mid-cycle.
   always @(negedge sb_clk) begin
      if (lt_valid)  n_lt++;
      if (at_valid) begin n_at++; at_t = $time; end
      if (frame_err) n_fe++;
      if (crc_err)   n_ce++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge sb_clk);
      #1;
   endtask

   task automatic send_char(input logic [7:0] b, input logic stopv = 1'b1);
      last_start_t = $time;
      sbrx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         sbrx = b[i];
         tick(CPB);
      end
      sbrx = stopv;
      tick(CPB);
   endtask

   task automatic send_stuffed(input logic [7:0] b);
      send_char(b);
      if (b == 8'hFE) send_char(8'hFE);
   endtask

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--)
         r = (r[15] ^ b[i]) ? ({r[14:0], 1'b0} ^ 16'h8005) : {r[14:0], 1'b0};
      return r;
   endfunction

   task automatic send_at(input logic [7:0] stx, input logic [127:0] pl, input int n,
                          input logic [7:0] flip);
      logic [15:0] c;
      c = crc_byte(16'hFFFF, stx);
      send_char(8'hFE);
      send_char(stx);
      for (int i = 0; i < n; i++) begin
         c = crc_byte(c, pl[8*i +: 8]);
         send_stuffed(pl[8*i +: 8]);
      end
      send_stuffed(c[15:8]);
      send_stuffed(c[7:0] ^ flip);
      send_char(8'hFE);
      send_char(8'h40);
   endtask

   task automatic send_lt(input logic [7:0] lse, input logic [7:0] chk);
      send_char(8'hFE);
      send_char(lse);
      send_char(chk);
   endtask

   task automatic test_reset;
      rst = 1'b1; enable = 1'b0; sbrx = 1'b1;
      tick(4);
      rst = 1'b0; enable = 1'b1;
      tick(3);
      n_cmp++; if ({lt_valid, at_valid, frame_err, crc_err, busy} !== 5'b0) begin
         n_err++; $display("FAIL reset_pulses: got %b want 00000", {lt_valid, at_valid, frame_err, crc_err, busy});
      end
      n_cmp++; if ({lt_lse, at_is_cmd, at_len, at_data} !== 77'b0) begin
         n_err++; $display("FAIL reset_data: got lse=%h cmd=%b len=%0d data=%h want all 0", lt_lse, at_is_cmd, at_len, at_data);
      end
   endtask

   task automatic test_lt_good(input logic [7:0] lse);
      int lt0, fe0;
      lt0 = n_lt; fe0 = n_fe;
      send_lt(lse, ~lse);
      tick(5);
      n_cmp++; if (n_lt - lt0 !== 1) begin n_err++; $display("FAIL lt_count: got %0d want 1", n_lt - lt0); end
      n_cmp++; if (lt_lse !== lse) begin n_err++; $display("FAIL lt_lse: got %h want %h", lt_lse, lse); end
      n_cmp++; if (n_fe - fe0 !== 0) begin n_err++; $display("FAIL lt_no_err: got %0d want 0", n_fe - fe0); end
   endtask

   task automatic test_lt_bad;
      int lt0, fe0;
      lt0 = n_lt; fe0 = n_fe;
      send_lt(8'h33, 8'hCD);
      tick(5);
      n_cmp++; if (n_fe - fe0 !== 1) begin n_err++; $display("FAIL ltbad_fe: got %0d want 1", n_fe - fe0); end
      n_cmp++; if (n_lt - lt0 !== 0) begin n_err++; $display("FAIL ltbad_lt: got %0d want 0", n_lt - lt0); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ltbad_busy: got %b want 0", busy); end
   endtask

   task automatic test_at(input string nm, input logic [7:0] stx, input logic [127:0] pl,
                          input int n, input logic [63:0] exp_data);
      int at0, fe0, ce0;
      at0 = n_at; fe0 = n_fe; ce0 = n_ce;
      send_at(stx, pl, n, 8'h00);
      n_cmp++; if (at_t !== last_start_t + 984) begin
         n_err++; $display("FAIL %s_timing: got t=%0t want t=%0t", nm, at_t, last_start_t + 984);
      end
      tick(5);
      n_cmp++; if (n_at - at0 !== 1 || n_fe != fe0 || n_ce != ce0) begin
         n_err++; $display("FAIL %s_pulses: got at=%0d fe=%0d ce=%0d want 1 0 0", nm, n_at - at0, n_fe - fe0, n_ce - ce0);
      end
      n_cmp++; if (at_is_cmd !== (stx == 8'h05)) begin n_err++; $display("FAIL %s_cmd: got %b want %b", nm, at_is_cmd, stx == 8'h05); end
      n_cmp++; if (at_len !== 4'(n)) begin n_err++; $display("FAIL %s_len: got %0d want %0d", nm, at_len, n); end
      n_cmp++; if (at_data !== exp_data) begin n_err++; $display("FAIL %s_data: got %h want %h", nm, at_data, exp_data); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_busy: got %b want 0", nm, busy); end
   endtask

   task automatic test_crc_bad;
      int at0, ce0;
      at0 = n_at; ce0 = n_ce;
      send_at(8'h05, 128'h22FE11, 3, 8'h01);
      tick(5);
`ifdef SB_RX_CRC_CHECK_EN
      n_cmp++; if (n_ce - ce0 !== 1 || n_at != at0) begin
         n_err++; $display("FAIL crcbad: got ce=%0d at=%0d want 1 0", n_ce - ce0, n_at - at0);
      end
`else
      n_cmp++; if (n_ce - ce0 !== 0 || n_at - at0 !== 1) begin
         n_err++; $display("FAIL crcbad: got ce=%0d at=%0d want 0 1", n_ce - ce0, n_at - at0);
      end
`endif
   endtask

   task automatic test_stop_err;
      int fe0, at0;
      fe0 = n_fe; at0 = n_at;
      send_char(8'hFE); send_char(8'h05); send_char(8'h11);
      send_char(8'h22, 1'b0);
      sbrx = 1'b1;
      tick(30);
      n_cmp++; if (n_fe - fe0 !== 1 || n_at != at0) begin
         n_err++; $display("FAIL stoperr: got fe=%0d at=%0d want 1 0", n_fe - fe0, n_at - at0);
      end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stoperr_busy: got %b want 0", busy); end
      test_lt_good(8'h5A);
   endtask

   task automatic test_overflow;
      int fe0, at0;
      logic [3:0] len0;
      logic [63:0] data0;
      fe0 = n_fe; at0 = n_at; len0 = at_len; data0 = at_data;
      send_char(8'hFE); send_char(8'h05);
      for (int i = 0; i < 11; i++) send_char(8'h11);
      tick(5);
      n_cmp++; if (n_fe - fe0 !== 1 || n_at != at0) begin
         n_err++; $display("FAIL overflow: got fe=%0d at=%0d want 1 0", n_fe - fe0, n_at - at0);
      end
      n_cmp++; if (at_len !== len0 || at_data !== data0) begin
         n_err++; $display("FAIL overflow_hold: got len=%0d data=%h want %0d %h", at_len, at_data, len0, data0);
      end
      test_lt_good(8'h3C);
   endtask

   task automatic test_glitch;
      int lt0, fe0, at0;
      lt0 = n_lt; fe0 = n_fe; at0 = n_at;
      sbrx = 1'b0; tick(3); sbrx = 1'b1;
      tick(200);
      n_cmp++; if (n_lt != lt0 || n_fe != fe0 || n_at != at0 || busy !== 1'b0) begin
         n_err++; $display("FAIL glitch: got lt=%0d fe=%0d at=%0d busy=%b want 0 0 0 0", n_lt - lt0, n_fe - fe0, n_at - at0, busy);
      end
   endtask

   task automatic test_reset_mid;
      send_char(8'hFE); send_char(8'h05); send_char(8'h11);
      rst = 1'b1; tick(2); rst = 1'b0; tick(2);
      n_cmp++; if ({lt_lse, at_is_cmd, at_len, at_data, busy} !== 78'b0) begin
         n_err++; $display("FAIL rstmid: got lse=%h cmd=%b len=%0d data=%h busy=%b want all 0", lt_lse, at_is_cmd, at_len, at_data, busy);
      end
      test_lt_good(8'h96);
   endtask

   task automatic test_enable;
      int lt0;
      lt0 = n_lt;
      enable = 1'b0;
      send_lt(8'h77, 8'h88);
      n_cmp++; if (n_lt != lt0 || busy !== 1'b0 || lt_lse !== 8'h96) begin
         n_err++; $display("FAIL enable_off: got lt=%0d busy=%b lse=%h want 0 0 96", n_lt - lt0, busy, lt_lse);
      end
      enable = 1'b1;
      tick(3);
      test_lt_good(8'h77);
   endtask

   task automatic test_back_to_back;
      int lt0;
      lt0 = n_lt;
      send_lt(8'h01, 8'hFE);
      send_lt(8'hA5, 8'h5A);
      tick(5);
      n_cmp++; if (n_lt - lt0 !== 2 || lt_lse !== 8'hA5) begin
         n_err++; $display("FAIL b2b: got cnt=%0d lse=%h want 2 a5", n_lt - lt0, lt_lse);
      end
   endtask

   initial begin
      test_reset();
      test_lt_good(8'h33);
      test_lt_bad();
      test_at("at_cmd", 8'h05, 128'h22FE11, 3, 64'h0000_0000_0022_FE11);
      test_crc_bad();
      test_at("at_empty", 8'h04, 128'h0, 0, 64'h0);
      test_at("at_max", 8'h05, 128'h0807_0605_0403_0201, 8, 64'h0807_0605_0403_0201);
      test_stop_err();
      test_overflow();
      test_glitch();
      test_reset_mid();
      test_enable();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
